// File: rtl/channel_select_ctrl.sv
// Channel select control for binary_encoder.
// Conditions three raw push-buttons (2-FF sync + debounce + press detect) and a
// scan-mode switch (2-FF sync), then drives a 2-bit channel index that is either
// stepped by hand or auto-scanned. A three-state FSM gates the enable output.
module channel_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_PERIOD     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_en,
    input  logic       scan_mode,
    output logic [1:0] val,
    output logic       en,
    output logic       step_pulse
);

    localparam int DEB_CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int SCAN_CW = $clog2(SCAN_PERIOD);
    localparam logic [DEB_CW-1:0]  DEB_LAST  = DEB_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_PERIOD - 1);

    // Button lane order: 0 = next, 1 = prev, 2 = enable toggle.
    localparam int B_NEXT = 0;
    localparam int B_PREV = 1;
    localparam int B_EN   = 2;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    logic [2:0]        btn_raw;
    logic [2:0]        btn_s1;
    logic [2:0]        btn_s2;
    logic [2:0]        btn_deb;
    logic [2:0]        btn_deb_q;
    logic [2:0]        btn_press;
    logic [DEB_CW-1:0] deb_cnt [3];

    logic scan_s1;
    logic scan_s2;

    state_t             state;
    state_t             state_next;
    logic [1:0]         val_next;
    logic [SCAN_CW-1:0] scan_timer;
    logic [SCAN_CW-1:0] scan_timer_next;

    logic next_press;
    logic prev_press;
    logic en_press;

    assign btn_raw    = {btn_en, btn_prev, btn_next};
    assign next_press = btn_press[B_NEXT];
    assign prev_press = btn_press[B_PREV];
    assign en_press   = btn_press[B_EN];

    // Synchronise, debounce and edge-detect the three buttons; sync the mode switch.
    // NOTE: the debounce counters are a small array but still get an explicit reset,
    // so a level held through reset must re-qualify from a zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_deb   <= '0;
            btn_deb_q <= '0;
            btn_press <= '0;
            scan_s1   <= 1'b0;
            scan_s2   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so s1 -> s2 -> deb form real pipeline stages.
            btn_s1    <= btn_raw;
            btn_s2    <= btn_s1;
            scan_s1   <= scan_mode;
            scan_s2   <= scan_s1;
            btn_deb_q <= btn_deb;
            btn_press <= btn_deb & ~btn_deb_q;
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == btn_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    btn_deb[i] <= btn_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_CW'(1);
                end
            end
        end
    end

    // FSM state, channel index, enable, step strobe and scan timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            val        <= 2'b00;
            en         <= 1'b0;
            step_pulse <= 1'b0;
            scan_timer <= '0;
        end else begin
            state      <= state_next;
            val        <= val_next;
            en         <= (state_next != ST_OFF);
            step_pulse <= (val_next != val);
            scan_timer <= scan_timer_next;
        end
    end

    // Next-state, next channel index and scan timer; enable press wins over everything.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_next      = state;
        val_next        = val;
        scan_timer_next = '0;
        unique case (state)
            ST_OFF: begin
                if (en_press) begin
                    state_next = scan_s2 ? ST_SCAN : ST_MANUAL;
                end
            end
            ST_MANUAL: begin
                if (en_press) begin
                    state_next = ST_OFF;
                end else begin
                    if (scan_s2) begin
                        state_next = ST_SCAN;
                    end
                    // Opposite presses in the same cycle cancel out.
                    if (next_press && !prev_press) begin
                        val_next = val + 2'd1;
                    end else if (prev_press && !next_press) begin
                        val_next = val - 2'd1;
                    end
                end
            end
            ST_SCAN: begin
                if (en_press) begin
                    state_next = ST_OFF;
                end else if (!scan_s2) begin
                    state_next = ST_MANUAL;
                end else if (scan_timer == SCAN_LAST) begin
                    val_next = val + 2'd1;
                end else begin
                    scan_timer_next = scan_timer + SCAN_CW'(1);
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

endmodule
